// File: rtl/piece_queue.sv
// ---------------------------------------------------------------------------
// piece_queue
//   Next-piece dispenser sitting behind the 7-piece bag collector. Completed
//   bags are appended to a shift-register FIFO of 3-bit pieces; the head and
//   a short look-ahead window are exported straight from the slot registers.
//   A one-cycle registered newbag pulse tells the collector to start over.
//
// Ports
//   clk          in   1          clock, rising edge
//   nreset       in   1          asynchronous active-low reset
//   bag_done     in   1          collector holds a complete bag
//   bag_in       in   21         packed bag, bits[3i+2:3i] = i-th piece
//   newbag       out  1          one-cycle registered pulse after a load
//   pop          in   1          consumer takes the head piece this cycle
//   piece_valid  out  1          head holds a real piece
//   piece        out  3          head of queue, 3'b111 when empty
//   preview      out  3*PREVIEW  [3k+2:3k] = slot k+1, 3'b111 when empty
//   count        out  CW         pieces currently buffered
// ---------------------------------------------------------------------------
module piece_queue #(
    parameter int DEPTH   = 14,
    parameter int PREVIEW = 3,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic                   bag_done,
    input  logic [20:0]            bag_in,
    output logic                   newbag,
    input  logic                   pop,
    output logic                   piece_valid,
    output logic [2:0]             piece,
    output logic [3*PREVIEW-1:0]   preview,
    output logic [CW-1:0]          count
);

    localparam logic [2:0] EMPTY = 3'b111;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t     state, state_nx;
    logic [2:0] s    [DEPTH];
    logic [2:0] s_nx [DEPTH];
    logic [CW-1:0] cnt_nx;
    logic [CW-1:0] base;
    logic          nb_nx;
    logic          do_pop;
    logic          do_load;

    // Extract piece idx of the packed bag using only constant slices.
    function automatic logic [2:0] bag_piece(input logic [20:0] bag, input int idx);
        logic [2:0] r;
        r = EMPTY;
        for (int i = 0; i < 7; i++) begin
            if (i == idx) r = bag[3*i +: 3];
        end
        return r;
    endfunction

    always_comb begin
        s_nx     = s;
        cnt_nx   = count;
        state_nx = state;
        nb_nx    = 1'b0;
        base     = count;

        do_pop  = pop && (count != '0);
        // Room check uses the pre-pop count, so a pop never enables a load
        // in the same cycle.
        do_load = (state == IDLE) && bag_done && (count <= CW'(DEPTH - 7));

        if (do_pop) begin
            for (int j = 0; j < DEPTH - 1; j++) begin
                s_nx[j] = s[j+1];
            end
            s_nx[DEPTH-1] = EMPTY;
            cnt_nx        = count - CW'(1);
            base          = count - CW'(1);
        end

        // Append after the shift so a simultaneous pop and load lands the bag
        // right behind the surviving pieces.
        if (do_load) begin
            for (int j = 0; j < DEPTH; j++) begin
                if ((j >= int'(base)) && (j < int'(base) + 7)) begin
                    s_nx[j] = bag_piece(bag_in, j - int'(base));
                end
            end
            cnt_nx = cnt_nx + CW'(7);
            nb_nx  = 1'b1;
        end

        case (state)
            IDLE:    if (do_load) state_nx = CLEAR;
            // Stay here while the collector still reports done so a stale
            // bag can never be taken twice.
            CLEAR:   if (!bag_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state  <= IDLE;
            count  <= '0;
            newbag <= 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                s[j] <= EMPTY;
            end
        end else begin
            state  <= state_nx;
            count  <= cnt_nx;
            newbag <= nb_nx;
            for (int j = 0; j < DEPTH; j++) begin
                s[j] <= s_nx[j];
            end
        end
    end

    assign piece       = s[0];
    assign piece_valid = (count != '0);

    for (genvar k = 0; k < PREVIEW; k++) begin : g_preview
        assign preview[3*k +: 3] = s[k+1];
    end

endmodule
